// File: rtl/mdu_unit_pkg.sv
// rtl/mdu_unit_pkg.sv - opcode/state encodings and decode helpers for the multiply/divide unit
package mdu_unit_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2
  } mdu_state_e;

  // Multi-cycle ops that occupy the unit
  function automatic logic op_is_arith(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_div(mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational signed/unsigned multiply and divide on latched operands
module mdu_calc (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        signed_i,
  input  logic        is_div_i,
  output logic [63:0] result_o,
  output logic        div_by_zero_o
);

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] q_mag, r_mag, q, r;
  logic [63:0] a_ext, b_ext, prod;

  // Sign-magnitude division (quotient toward zero, remainder follows dividend);
  // sign-extended 64-bit product gives both signed and unsigned multiply.
  always_comb begin
    a_neg  = signed_i & a_i[31];
    b_neg  = signed_i & b_i[31];
    a_mag  = a_neg ? (32'd0 - a_i) : a_i;
    b_mag  = b_neg ? (32'd0 - b_i) : b_i;
    // Divisor forced non-zero so the divider never sees x/0; the result is discarded then.
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    q      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    r      = a_neg ? (32'd0 - r_mag) : r_mag;
    a_ext  = {{32{a_neg}}, a_i};
    b_ext  = {{32{b_neg}}, b_i};
    prod   = a_ext * b_ext;
    result_o      = is_div_i ? {r, q} : prod;
    div_by_zero_o = is_div_i & (b_i == 32'd0);
  end

endmodule

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit owning HI/LO for the E stage
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDU_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic             sgn_q, sgn_d;
  logic             accept;
  logic [63:0]      calc_res;
  logic             calc_dbz;
  mdu_op_e          op;

  assign op = mdu_op_e'(MDU_op);

  mdu_calc u_calc (
    .a_i          (a_q),
    .b_i          (b_q),
    .signed_i     (sgn_q),
    .is_div_i     (state_q == S_DIV),
    .result_o     (calc_res),
    .div_by_zero_o(calc_dbz)
  );

  // Next-state: launch ops from IDLE or on the completing edge, count down, write back
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept = op_is_arith(op);
          if (op == MDU_MTHI) hi_d = A;
          if (op == MDU_MTLO) lo_d = A;
        end
      end
      S_MULT, S_DIV: begin
        if (cnt_q == '0) begin
          if (!calc_dbz) {hi_d, lo_d} = calc_res;
          state_d = S_IDLE;
          // A new mult/div may launch on the very edge the previous one retires
          accept  = start & op_is_arith(op);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      a_d   = A;
      b_d   = B;
      sgn_d = op_is_signed(op);
      if (op_is_div(op)) begin
        state_d = S_DIV;
        cnt_d   = CNT_W'(DIV_CYCLES - 1);
      end else begin
        state_d = S_MULT;
        cnt_d   = CNT_W'(MULT_CYCLES - 1);
      end
    end
  end

  // State, counter, operand latches and HI/LO; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Move-from read port: current HI/LO, no latency
  always_comb begin
    MDU_out = 32'd0;
    if (op == MDU_MFHI) MDU_out = hi_q;
    if (op == MDU_MFLO) MDU_out = lo_q;
  end

  assign busy = (state_q != S_IDLE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - scoreboard bench for mdu_unit with directed vectors
module tb_mdu_unit;

  localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_MULTU = 4'd2, OP_DIV = 4'd3,
                         OP_DIVU = 4'd4, OP_MFHI = 4'd5, OP_MFLO = 4'd6, OP_MTHI = 4'd7,
                         OP_MTLO = 4'd8;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [3:0]  MDU_op = OP_NONE;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] HI, LO, MDU_out;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .MDU_op(MDU_op), .start(start),
    .busy(busy), .HI(HI), .LO(LO), .MDU_out(MDU_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    exp_t e;
    e.hi = hi; e.lo = lo; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Apply one start for one edge, then scramble operands to prove capture
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    A = a; B = b; MDU_op = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; MDU_op = OP_NONE; A = $urandom; B = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL wait_idle: busy still 1 after 40 cycles, expected 0");
    end
    @(posedge clk); #1;
  endtask

  // Monitor: each falling edge of busy (outside reset) is one completed op
  initial begin : monitor
    logic prev_busy;
    int   cyc;
    exp_t e;
    prev_busy = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cyc = 0;
      end else if (busy) begin
        cyc++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: unexpected completion hi=0x%08h lo=0x%08h", HI, LO);
        end else begin
          e = sb.pop_front();
          check("done_hi", HI, e.hi);
          check("done_lo", LO, e.lo);
          check("busy_cycles", 32'(cyc), 32'(e.cyc));
        end
        cyc = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", MDU_out, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    push(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    wait_idle();

    push(32'hFFFFFFFE, 32'h00000001, 5);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle();

    push(32'h40000000, 32'h00000000, 5);
    issue(OP_MULT, 32'h80000000, 32'h80000000);
    wait_idle();

    push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle();

    push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_idle();

    push(32'h00000001, 32'hFFFFFFFD, 10);
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_idle();

    push(32'd2, 32'd14, 10);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle();

    push(32'h00000000, 32'h80000000, 10);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();

    // mthi, then read both halves combinationally
    issue(OP_MTHI, 32'h1234, 32'd0);
    check("mthi_hi", HI, 32'h1234);
    MDU_op = OP_MFHI; #1;
    check("mfhi_out", MDU_out, 32'h1234);
    MDU_op = OP_MFLO; #1;
    check("mflo_out", MDU_out, 32'h80000000);
    MDU_op = OP_NONE;
    issue(OP_MTLO, 32'h55AA, 32'd0);
    check("mtlo_lo", LO, 32'h55AA);

    // mult 5*6; while busy: mfhi sees old HI, stray mthi/mult starts are ignored
    push(32'd0, 32'd30, 5);
    issue(OP_MULT, 32'd5, 32'd6);
    MDU_op = OP_MFHI; #1;
    check("mfhi_busy", MDU_out, 32'h1234);
    issue(OP_MTHI, 32'hDEAD, 32'd0);
    check("mthi_busy_ignored", HI, 32'h1234);
    issue(OP_MULTU, 32'd9, 32'd9);
    wait_idle();

    // reset in the middle of a mult: immediate clear, no later writeback
    issue(OP_MULT, 32'd3, 32'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0; #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    @(negedge clk); #2;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_wb_lo", LO, 32'd0);
    check("abort_no_wb_busy", 32'(busy), 32'd0);

    // back-to-back: second mult accepted on the retiring edge of the first
    push(32'd0, 32'd90, 10);
    issue(OP_MULT, 32'd7, 32'd8);
    repeat (4) @(posedge clk);
    #1;
    A = 32'd9; B = 32'd10; MDU_op = OP_MULT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; MDU_op = OP_NONE; A = $urandom; B = $urandom;
    check("b2b_first_lo", LO, 32'd56);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_idle();
    MDU_op = OP_MFLO; #1;
    check("b2b_mflo", MDU_out, 32'd90);
    MDU_op = OP_NONE;

    repeat (2) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
